clock_ctrl: RTL and testbench
=============================

Name: clock_ctrl

Overview:
Mode/sequencing controller for the hour/minute/second mod-N counter chain of the digital clock.
- Generates the 1 Hz timebase and turns two push buttons (mode, inc) into clean single-cycle pulses.
- Runs a RUN/SET state machine and drives the per-field counter enables.
- Gates the counter carry chain, so counters only ever see a count enable from this block.

Parameters:
CLK_HZ, 50_000_000, input clock frequency; prescaler terminal count is CLK_HZ-1.
PW, $clog2(CLK_HZ), prescaler width (derived, not overridden).
TIMEOUT_S, 30, idle seconds before a SET state auto-returns to RUN (optional feature only).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
mode_btn  input  1  raw mode button, asynchronous, active-high
inc_btn  input  1  raw increment button, asynchronous, active-high
sec_tc  input  1  terminal-count flag from seconds counter
min_tc  input  1  terminal-count flag from minutes counter
sec_en  output  1  seconds counter enable
min_en  output  1  minutes counter enable
hour_en  output  1  hours counter enable
mode  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
blink_mask  output  3  display blank mask {hour,min,sec}, 1 = blank field
tick  output  1  1 Hz single-cycle strobe (debug/display)

Behaviour:
- Reset values (asynchronous, immediate, also mid-operation):
  - state RUN, prescaler 0, blink phase 0, idle count 0.
  - sec_en, min_en, hour_en, tick, blink_mask and mode all 0.
  - Button sync and prev registers reset to 1. A button held through reset release produces no pulse.
- Prescaler:
  - Counts 0..CLK_HZ-1 and wraps; runs in all states.
  - tick = 1 for exactly the cycle where count == CLK_HZ-1.
  - Blink phase toggles when count == CLK_HZ/2-1 and when count == CLK_HZ-1, giving 1 Hz at 50% duty.
- Buttons:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detect.
  - The pulse is high for 1 cycle, in the 3rd cycle after the clk edge that first samples the button high.
  - One pulse per press; a held button never repeats.
- State machine, advanced on mode_p: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
- Enables (combinational from state, tick, pulses and tc inputs):
  - RUN: sec_en = tick; min_en = sec_tc; hour_en = min_tc. This relies on the counters' tc already being qualified by their enable.
  - SET_HOUR: hour_en = inc_p; the other two enables are 0.
  - SET_MIN: min_en = inc_p; the other two enables are 0.
  - SET_SEC: sec_en = inc_p; the other two enables are 0.
  - In every SET state, sec_tc and min_tc are ignored, so no carry ripples from a manual increment.
- blink_mask:
  - In a SET state, the selected field's bit = blink phase; all other bits 0.
  - In RUN, blink_mask = 000.
- Simultaneous mode_p and inc_p in the same cycle: the state advances and inc_p is discarded (no enable pulse).
- SET_SEC -> RUN transition: the prescaler clears to 0, so the first running second is a full CLK_HZ cycles.
- Any entry into a SET state clears the blink phase to 0, so the selected field is visible first.

Optional Feature:
CLOCK_CTRL_TIMEOUT_EN
- Defined:
  - In SET states an idle counter increments on each tick and clears on any mode_p or inc_p.
  - When it reaches TIMEOUT_S, the state returns to RUN and the prescaler clears (same as the SET_SEC -> RUN transition).
  - The idle counter is cleared in RUN.
- Undefined: no idle counter; SET states persist until a mode press.

Decomposition:
- Package clock_pkg:
  - state typedef with encodings RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3;
  - blink bit index constants HOUR_BIT=2, MIN_BIT=1, SEC_BIT=0.
- One sub-module, btn_edge: 2-FF synchronizer plus rising-edge pulse, registers reset to 1. Instantiated twice (mode, inc).

Test Plan (bench overrides CLK_HZ=10, TIMEOUT_S=3):
1. Release reset, hold buttons low -> tick and sec_en high on cycles 10, 20, 30 only; min_en and hour_en stay 0; mode=0.
2. RUN, force sec_tc=1 in a tick cycle, then min_tc=1 -> min_en=1 in that same cycle; hour_en=1 while min_tc=1.
3. Four mode presses ->
   - mode steps 1, 2, 3, 0;
   - blink_mask is 100/000, then 010/000, then 001/000, toggling every 5 cycles;
   - blink_mask returns to 000 in RUN.
4. SET_MIN, three inc presses with sec_tc and min_tc forced 1 -> exactly three 1-cycle min_en pulses; sec_en and hour_en stay 0.
5. SET_HOUR, mode_btn and inc_btn rise on the same edge -> mode=2, no hour_en pulse. Then assert reset mid-SET -> mode=0 and all outputs 0 immediately.
6. SET_HOUR with buttons idle for 30 cycles ->
   - macro defined: mode=0 at the 3rd tick, and the next tick arrives 10 cycles later;
   - macro undefined: mode stays 1.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock mode/sequencing controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam int unsigned HOUR_BIT = 2;
  localparam int unsigned MIN_BIT  = 1;
  localparam int unsigned SEC_BIT  = 0;

  // Mode button cycles RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  function automatic state_t next_mode(input state_t s);
    case (s)
      RUN:      return SET_HOUR;
      SET_HOUR: return SET_MIN;
      SET_MIN:  return SET_SEC;
      default:  return RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus rising-edge detector producing a registered 1-cycle pulse.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Sync/prev reset high so a button held through reset release never pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// RUN/SET controller for the h/m/s counter chain: 1 Hz timebase, button pulses, counter enables.
// Optional SET-state idle timeout enabled by defining CLOCK_CTRL_TIMEOUT_EN.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       sec_tc,
  input  logic       min_tc,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic [1:0] mode,
  output logic [2:0] blink_mask,
  output logic       tick
);

  localparam int unsigned PW = $clog2(CLK_HZ);

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   count;
  logic            blink;
  logic            half;
  logic            mode_p;
  logic            inc_p;
  logic            pre_clr;
  logic            blink_clr;
  logic            timeout;

  btn_edge u_mode_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (mode_btn),
    .pulse (mode_p)
  );

  btn_edge u_inc_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (inc_btn),
    .pulse (inc_p)
  );

  assign tick = (count == PW'(CLK_HZ - 1));
  assign half = (count == PW'(CLK_HZ / 2 - 1));
  assign mode = state;

`ifdef CLOCK_CTRL_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_S + 1);

  logic [IW-1:0] idle_cnt;

  // Idle seconds spent in a SET state; any button activity restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state == RUN || mode_p || inc_p || timeout) begin
      idle_cnt <= '0;
    end else if (tick) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  assign timeout = (state != RUN) && tick && !mode_p && !inc_p &&
                   (idle_cnt == IW'(TIMEOUT_S - 1));
`else
  logic [31:0] timeout_unused;

  assign timeout_unused = 32'(TIMEOUT_S);
  assign timeout        = 1'b0;
`endif

  // Leaving SET back to RUN restarts the second so the first one is full length.
  assign pre_clr   = (state == SET_SEC && mode_p) || timeout;
  assign blink_clr = (state_next != state) && (state_next != RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (pre_clr || tick) begin
      count <= '0;
    end else begin
      count <= count + PW'(1);
    end
  end

  // Blink phase: 1 Hz square wave, restarted visible on each SET entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink <= 1'b0;
    end else if (blink_clr) begin
      blink <= 1'b0;
    end else if (tick || half) begin
      blink <= ~blink;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (mode_p) begin
      state_next = next_mode(state);
    end else if (timeout) begin
      state_next = RUN;
    end
  end

  // SET states ignore carries and drop an inc that coincides with a mode press.
  always_comb begin
    sec_en     = 1'b0;
    min_en     = 1'b0;
    hour_en    = 1'b0;
    blink_mask = 3'b000;
    case (state)
      RUN: begin
        sec_en  = tick;
        min_en  = sec_tc;
        hour_en = min_tc;
      end
      SET_HOUR: begin
        hour_en              = inc_p & ~mode_p;
        blink_mask[HOUR_BIT] = blink;
      end
      SET_MIN: begin
        min_en              = inc_p & ~mode_p;
        blink_mask[MIN_BIT] = blink;
      end
      SET_SEC: begin
        sec_en              = inc_p & ~mode_p;
        blink_mask[SEC_BIT] = blink;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed self-checking bench for clock_ctrl with CLK_HZ=10, TIMEOUT_S=3.
module tb_clock_ctrl;

  localparam int unsigned CLK_HZ    = 10;
  localparam int unsigned TIMEOUT_S = 3;

  logic       clk;
  logic       reset;
  logic       mode_btn;
  logic       inc_btn;
  logic       sec_tc;
  logic       min_tc;
  logic       sec_en;
  logic       min_en;
  logic       hour_en;
  logic [1:0] mode;
  logic [2:0] blink_mask;
  logic       tick;

  int         ntests;
  int         nfail;
  int         pc;
  logic       blink_m;
  logic [1:0] ms;
  int         pulses;
  int         hits;
  int         gap;
  logic       gap_armed;
  logic       hit;

  clock_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_S (TIMEOUT_S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_btn   (mode_btn),
    .inc_btn    (inc_btn),
    .sec_tc     (sec_tc),
    .min_tc     (min_tc),
    .sec_en     (sec_en),
    .min_en     (min_en),
    .hour_en    (hour_en),
    .mode       (mode),
    .blink_mask (blink_mask),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] exp_mask();
    case (ms)
      2'd1:    return {blink_m, 2'b00};
      2'd2:    return {1'b0, blink_m, 1'b0};
      2'd3:    return {2'b00, blink_m};
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; track expected prescaler count and blink phase.
  task automatic cyc();
    int pp;
    @(negedge clk);
    pp = pc;
    pc = (pc + 1) % int'(CLK_HZ);
    if (pp == int'(CLK_HZ / 2 - 1) || pp == int'(CLK_HZ - 1)) blink_m = ~blink_m;
  endtask

  task automatic chk_state();
    chk("mode", 32'(mode), 32'(ms));
    chk("blink_mask", 32'(blink_mask), 32'(exp_mask()));
    chk("tick", 32'(tick), 32'(pc == int'(CLK_HZ - 1)));
  endtask

  task automatic step();
    cyc();
    chk_state();
  endtask

  // Mode press: state moves on the 4th edge after the button is driven high.
  task automatic press_mode();
    mode_btn = 1'b1;
    repeat (3) step();
    cyc();
    mode_btn = 1'b0;
    ms = ms + 2'd1;
    if (ms == 2'd0) pc = 0;
    else blink_m = 1'b0;
    chk_state();
    repeat (2) step();
  endtask

  initial begin
    ntests = 0; nfail = 0; pc = 0; blink_m = 1'b0; ms = 2'd0;
    pulses = 0; hits = 0; gap = 0; gap_armed = 1'b0; hit = 1'b0;
    reset = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0; sec_tc = 1'b0; min_tc = 1'b0;

    @(negedge clk);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_sec_en", 32'(sec_en), 0);
    chk("rst_min_en", 32'(min_en), 0);
    chk("rst_hour_en", 32'(hour_en), 0);
    chk("rst_blink", 32'(blink_mask), 0);
    chk("rst_tick", 32'(tick), 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: free-running timebase in RUN
    for (int k = 1; k <= 30; k++) begin
      step();
      chk("t1_sec_en", 32'(sec_en), 32'(pc == int'(CLK_HZ - 1)));
      chk("t1_min_en", 32'(min_en), 0);
      chk("t1_hour_en", 32'(hour_en), 0);
    end

    // 2: carry chain pass-through in RUN
    repeat (9) step();
    sec_tc = 1'b1;
    #1;
    chk("t2_sec_en_tick", 32'(sec_en), 1);
    chk("t2_min_en_carry", 32'(min_en), 1);
    sec_tc = 1'b0;
    min_tc = 1'b1;
    #1;
    chk("t2_hour_en_carry", 32'(hour_en), 1);
    chk("t2_min_en_off", 32'(min_en), 0);
    min_tc = 1'b0;
    #1;
    chk("t2_hour_en_off", 32'(hour_en), 0);

    // 3: full mode cycle with blinking field
    repeat (4) begin
      press_mode();
      repeat (12) step();
    end
    chk("t3_back_to_run", 32'(mode), 0);

    // 4: manual minute increments ignore forced carries
    press_mode();
    press_mode();
    sec_tc = 1'b1;
    min_tc = 1'b1;
    for (int p = 0; p < 3; p++) begin
      inc_btn = 1'b1;
      for (int i = 1; i <= 6; i++) begin
        cyc();
        chk_state();
        chk("t4_min_en", 32'(min_en), 32'(i == 3));
        chk("t4_sec_en", 32'(sec_en), 0);
        chk("t4_hour_en", 32'(hour_en), 0);
        pulses += int'(min_en);
        if (i == 4) inc_btn = 1'b0;
      end
    end
    chk("t4_pulse_count", 32'(pulses), 3);
    sec_tc = 1'b0;
    min_tc = 1'b0;

    // 5: simultaneous mode+inc in SET_HOUR, then async reset mid-SET
    press_mode();
    press_mode();
    press_mode();
    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 4) begin
        ms = 2'd2;
        blink_m = 1'b0;
      end
      chk_state();
      chk("t5_hour_en", 32'(hour_en), 0);
      chk("t5_min_en", 32'(min_en), 0);
    end
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    #1;
    chk("t5_rst_mode", 32'(mode), 0);
    chk("t5_rst_blink", 32'(blink_mask), 0);
    chk("t5_rst_sec_en", 32'(sec_en), 0);
    chk("t5_rst_min_en", 32'(min_en), 0);
    chk("t5_rst_hour_en", 32'(hour_en), 0);
    chk("t5_rst_tick", 32'(tick), 0);
    mode_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    pc = 0; blink_m = 1'b0; ms = 2'd0;
    repeat (6) step();
    mode_btn = 1'b0;
    repeat (3) step();

    // 6: idle in SET_HOUR
    mode_btn = 1'b1;
    repeat (3) step();
    cyc();
    mode_btn = 1'b0;
    ms = 2'd1;
    blink_m = 1'b0;
    chk_state();
    for (int k = 0; k < 45; k++) begin
      hit = (ms != 2'd0) && (pc == int'(CLK_HZ - 1));
      cyc();
`ifdef CLOCK_CTRL_TIMEOUT_EN
      if (hit) begin
        hits++;
        if (hits == int'(TIMEOUT_S)) begin
          ms = 2'd0;
          pc = 0;
          gap = 0;
          gap_armed = 1'b1;
        end
      end
`endif
      chk_state();
      if (gap_armed) begin
        gap++;
        if (tick) begin
          chk("t6_tick_gap", 32'(gap), 10);
          gap_armed = 1'b0;
        end
      end
    end
`ifdef CLOCK_CTRL_TIMEOUT_EN
    chk("t6_timeout_mode", 32'(mode), 0);
`else
    chk("t6_persist_mode", 32'(mode), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
